// File: rtl/display_scan_mux.sv
// Four-digit hex scan multiplexer feeding one shared 7-segment decoder.
// Each digit slot is a blanking gap followed by a prescaled drive period.
module display_scan_mux #(
    parameter int unsigned DIV_WIDTH  = 16,
    parameter int unsigned DIV_MAX    = 49999,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic [3:0]  blank_mask,
    output logic        w,
    output logic        x,
    output logic        y,
    output logic        z,
    output logic [3:0]  an,
    output logic        frame_start
);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [DIV_WIDTH-1:0] PRESC_LAST = DIV_WIDTH'(DIV_MAX);
    localparam logic [DIV_WIDTH-1:0] PRESC_ONE  = DIV_WIDTH'(1);
    localparam logic [7:0]           GAP_LAST   = 8'(GAP_CYCLES - 1);

    state_t               state_q, state_d;
    logic [15:0]          shadow_q, shadow_d;
    logic [1:0]           idx_q, idx_d;
    logic [DIV_WIDTH-1:0] presc_q, presc_d;
    logic [7:0]           gap_q, gap_d;
    logic [3:0]           nib_q, nib_d;
    logic [3:0]           an_q, an_d;
    logic                 fs_q, fs_d;

    // Next-state: slot sequencing, shadow capture and registered outputs
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        presc_d  = presc_q;
        gap_d    = gap_q;
        fs_d     = 1'b0;
        shadow_d = load ? value : shadow_q;
        // Nibble follows the current index; the gap hides the one-cycle lag
        nib_d    = shadow_q[{idx_q, 2'b00} +: 4];

        unique case (state_q)
            BLANK: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = 8'd0;
                    presc_d = '0;
                    state_d = DRIVE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            DRIVE: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    idx_d   = idx_q + 2'd1;
                    state_d = BLANK;
                    fs_d    = (idx_q == 2'd3);
                end else begin
                    presc_d = presc_q + PRESC_ONE;
                end
            end
        endcase

        // Anode tracks the state being entered so it switches with the FSM
        if (state_d == DRIVE && !blank_mask[idx_d]) begin
            an_d = ~(4'b0001 << idx_d);
        end else begin
            an_d = 4'b1111;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= BLANK;
            shadow_q <= 16'h0000;
            idx_q    <= 2'd0;
            presc_q  <= '0;
            gap_q    <= 8'd0;
            nib_q    <= 4'b0000;
            an_q     <= 4'b1111;
            fs_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            presc_q  <= presc_d;
            gap_q    <= gap_d;
            nib_q    <= nib_d;
            an_q     <= an_d;
            fs_q     <= fs_d;
        end
    end

    assign {w, x, y, z} = nib_q;
    assign an           = an_q;
    assign frame_start  = fs_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed bench for display_scan_mux with a short prescaler.
// Slot = 2 blank + 4 drive cycles; frame = 24 cycles.
module tb_display_scan_mux;

    localparam int DIVM = 3;
    localparam int GAP  = 2;
    localparam int SLOT = GAP + DIVM + 1;

    typedef struct {
        logic        ld;
        logic [15:0] val;
        logic [3:0]  msk;
        logic [3:0]  an;
        logic [3:0]  nib;
        logic        fs;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic [3:0]  blank_mask = 4'b0000;
    logic        w, x, y, z, frame_start;
    logic [3:0]  an;

    display_scan_mux #(
        .DIV_WIDTH (16),
        .DIV_MAX   (DIVM),
        .GAP_CYCLES(GAP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .blank_mask (blank_mask),
        .w          (w),
        .x          (x),
        .y          (y),
        .z          (z),
        .an         (an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int k,
                       input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s k=%0d got %b want %b", nm, k, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int k, input logic [3:0] e_an,
                           input logic [3:0] e_nib, input logic e_fs);
        chk({tag, ".an"}, k, an, e_an);
        chk({tag, ".wxyz"}, k, {w, x, y, z}, e_nib);
        chk({tag, ".fs"}, k, {3'b000, frame_start}, {3'b000, e_fs});
    endtask

    // Two reset edges, then release; sample point is k=0
    task automatic do_reset(input string tag);
        rst = 1'b1;
        load = 1'b0;
        blank_mask = 4'b0000;
        tick;
        tick;
        chk_all({tag, ".rst"}, 0, 4'b1111, 4'b0000, 1'b0);
        rst = 1'b0;
    endtask

    // Expected trace for edges 1..n after reset; optional load on edge 1
    task automatic build(input logic [15:0] val, input logic [3:0] msk,
                         input bit doload, input int n);
        vec_t        r;
        int          m, d, id;
        logic [15:0] sh;
        vecs.delete();
        for (int k = 1; k <= n; k++) begin
            m  = k % SLOT;
            d  = (k / SLOT) % 4;
            id = (m == 0) ? (d + 3) % 4 : d;
            sh = (doload && k > 1) ? val : 16'h0000;
            r.ld  = doload && (k == 1);
            r.val = val;
            r.msk = msk;
            r.an  = (m < GAP || msk[d]) ? 4'b1111 : 4'(~(4'b0001 << d));
            r.nib = 4'(sh >> (4 * id));
            r.fs  = (k % (4 * SLOT) == 0);
            vecs.push_back(r);
        end
    endtask

    task automatic apply(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            load = vecs[i].ld;
            value = vecs[i].val;
            blank_mask = vecs[i].msk;
            tick;
            chk_all(tag, i + 1, vecs[i].an, vecs[i].nib, vecs[i].fs);
        end
        load = 1'b0;
    endtask

    initial begin
        int          d;
        logic [3:0]  e_an;
        logic [3:0]  e_nib;

        // Reset, scan order and two frame wraps
        do_reset("scan");
        build(16'h4321, 4'b0000, 1'b1, 50);
        apply("scan");

        // Digit 2 masked off
        do_reset("mask");
        build(16'hABCD, 4'b0100, 1'b1, 26);
        apply("mask");
        blank_mask = 4'b0000;

        // Reset during digit-2 drive, restart with cleared shadow
        do_reset("mid");
        build(16'h4321, 4'b0000, 1'b1, 14);
        apply("mid");
        rst = 1'b1;
        tick;
        chk_all("mid.rst", 0, 4'b1111, 4'b0000, 1'b0);
        rst = 1'b0;
        build(16'h9999, 4'b0000, 1'b0, 26);
        apply("restart");

        // Load on the edge that ends digit 2
        do_reset("ldchg");
        build(16'h4321, 4'b0000, 1'b1, 17);
        apply("ldchg");
        load = 1'b1;
        value = 16'hF000;
        tick;
        chk_all("ldchg.edge", 18, 4'b1111, 4'b0011, 1'b0);
        load = 1'b0;
        value = 16'h0000;
        for (int k = 19; k <= 29; k++) begin
            tick;
            d = (k / SLOT) % 4;
            e_an = (k % SLOT < GAP) ? 4'b1111 : 4'(~(4'b0001 << d));
            e_nib = (k <= 24) ? 4'b1111 : 4'b0000;
            chk_all("ldchg.post", k, e_an, e_nib, k == 24);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
